// File: rtl/rgb_to_ycbcr_stream.sv
// Streaming RGB-to-YCbCr converter: 3-stage valid/ready pipeline with full backpressure,
// per-frame full/limited range selection, rounding, saturation and a per-frame clip counter.
module rgb_to_ycbcr_stream #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_mode,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [3*DW-1:0]  i_s_data,
    input  logic             i_s_sof,
    input  logic             i_s_eol,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [3*DW-1:0]  o_m_data,
    output logic             o_m_sof,
    output logic             o_m_eol,
    output logic [CNT_W-1:0] o_clip_cnt
);

    localparam int unsigned PW = DW + 8;
    localparam int unsigned SW = DW + 10;

    typedef logic signed [SW-1:0] sum_t;

    localparam sum_t Round   = sum_t'(128);
    localparam sum_t OffYLim = sum_t'(16 * (1 << DW));
    localparam sum_t OffC    = sum_t'(1 << (DW + 7));
    localparam sum_t FullHi  = sum_t'((1 << DW) - 1);
    localparam sum_t LimLo   = sum_t'(16 << (DW - 8));
    localparam sum_t LimYHi  = sum_t'(235 << (DW - 8));
    localparam sum_t LimCHi  = sum_t'(240 << (DW - 8));

    function automatic sum_t ext(input logic [PW-1:0] p);
        return sum_t'(p);
    endfunction

    // Returns {clipped, value} after dropping the 8 fractional bits.
    function automatic logic [DW:0] clamp(input sum_t v, input sum_t lo, input sum_t hi);
        sum_t s;
        s = v >>> 8;
        if (s < lo) begin
            clamp = {1'b1, lo[DW-1:0]};
        end else if (s > hi) begin
            clamp = {1'b1, hi[DW-1:0]};
        end else begin
            clamp = {1'b0, s[DW-1:0]};
        end
    endfunction

    logic             w_adv;
    logic             w_mode_px;
    logic [DW-1:0]    w_chan [3];
    logic [7:0]       w_coef [9];
    logic [PW-1:0]    w_prod [9];

    logic             r_mode_lat;
    logic             r_v1, r_sof1, r_eol1, r_mode1;
    logic [PW-1:0]    r_prod1 [9];

    sum_t             w_sum_y, w_sum_cb, w_sum_cr;
    logic             r_v2, r_sof2, r_eol2, r_mode2;
    sum_t             r_sum_y2, r_sum_cb2, r_sum_cr2;

    sum_t             w_lo, w_hi_y, w_hi_c;
    logic [DW:0]      w_cy, w_ccb, w_ccr;
    logic             w_clip;
    logic [CNT_W-1:0] w_cnt_next;

    logic             r_v3, r_sof3, r_eol3;
    logic [3*DW-1:0]  r_data3;
    logic [CNT_W-1:0] r_clip_cnt;

    // Stage 3 empty or being drained: the whole pipeline moves.
    assign w_adv     = ~r_v3 | i_m_ready;
    assign o_s_ready = w_adv;
    assign w_mode_px = i_s_sof ? i_mode : r_mode_lat;

    always_comb begin
        w_chan[0] = i_s_data[3*DW-1 -: DW];
        w_chan[1] = i_s_data[2*DW-1 -: DW];
        w_chan[2] = i_s_data[DW-1:0];
        if (w_mode_px) begin
            w_coef = '{8'd66, 8'd129, 8'd25, 8'd38, 8'd74, 8'd112, 8'd112, 8'd94, 8'd18};
        end else begin
            w_coef = '{8'd77, 8'd150, 8'd29, 8'd43, 8'd85, 8'd128, 8'd128, 8'd107, 8'd21};
        end
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = PW'(w_chan[k % 3]) * PW'(w_coef[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_lat <= 1'b0;
        end else if (i_s_valid && w_adv && i_s_sof) begin
            r_mode_lat <= i_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_sof1  <= 1'b0;
            r_eol1  <= 1'b0;
            r_mode1 <= 1'b0;
            r_prod1 <= '{default: '0};
        end else if (w_adv) begin
            r_v1    <= i_s_valid;
            r_sof1  <= i_s_sof;
            r_eol1  <= i_s_eol;
            r_mode1 <= w_mode_px;
            r_prod1 <= w_prod;
        end
    end

    // Cb/Cr sums cannot go negative for any input, but stay signed for clarity of the clamp.
    always_comb begin
        w_sum_y  = ext(r_prod1[0]) + ext(r_prod1[1]) + ext(r_prod1[2])
                 + (r_mode1 ? OffYLim : '0) + Round;
        w_sum_cb = OffC + Round + ext(r_prod1[5]) - ext(r_prod1[3]) - ext(r_prod1[4]);
        w_sum_cr = OffC + Round + ext(r_prod1[6]) - ext(r_prod1[7]) - ext(r_prod1[8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2      <= 1'b0;
            r_sof2    <= 1'b0;
            r_eol2    <= 1'b0;
            r_mode2   <= 1'b0;
            r_sum_y2  <= '0;
            r_sum_cb2 <= '0;
            r_sum_cr2 <= '0;
        end else if (w_adv) begin
            r_v2      <= r_v1;
            r_sof2    <= r_sof1;
            r_eol2    <= r_eol1;
            r_mode2   <= r_mode1;
            r_sum_y2  <= w_sum_y;
            r_sum_cb2 <= w_sum_cb;
            r_sum_cr2 <= w_sum_cr;
        end
    end

    always_comb begin
        w_lo   = r_mode2 ? LimLo : '0;
        w_hi_y = r_mode2 ? LimYHi : FullHi;
        w_hi_c = r_mode2 ? LimCHi : FullHi;
        w_cy   = clamp(r_sum_y2, w_lo, w_hi_y);
        w_ccb  = clamp(r_sum_cb2, w_lo, w_hi_c);
        w_ccr  = clamp(r_sum_cr2, w_lo, w_hi_c);
        w_clip = w_cy[DW] | w_ccb[DW] | w_ccr[DW];
        w_cnt_next = r_clip_cnt;
        if (r_sof2) begin
            w_cnt_next = CNT_W'(w_clip);
        end else if (w_clip && (r_clip_cnt != '1)) begin
            w_cnt_next = r_clip_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3       <= 1'b0;
            r_sof3     <= 1'b0;
            r_eol3     <= 1'b0;
            r_data3    <= '0;
            r_clip_cnt <= '0;
        end else if (w_adv) begin
            r_v3    <= r_v2;
            r_sof3  <= r_sof2;
            r_eol3  <= r_eol2;
            r_data3 <= {w_cy[DW-1:0], w_ccb[DW-1:0], w_ccr[DW-1:0]};
            if (r_v2) begin
                r_clip_cnt <= w_cnt_next;
            end
        end
    end

    assign o_m_valid  = r_v3;
    assign o_m_data   = r_data3;
    assign o_m_sof    = r_sof3;
    assign o_m_eol    = r_eol3;
    assign o_clip_cnt = r_clip_cnt;

endmodule

// File: tb/tb_rgb_to_ycbcr_stream.sv
// Scoreboard bench for rgb_to_ycbcr_stream (DW=8): directed colour points, random
// backpressure streaming, stall/resume throughput and mid-frame reset.
module tb_rgb_to_ycbcr_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_mode, i_s_valid, i_s_sof, i_s_eol, i_m_ready;
    logic [23:0] i_s_data;
    logic        o_s_ready, o_m_valid, o_m_sof, o_m_eol;
    logic [23:0] o_m_data;
    logic [15:0] o_clip_cnt;

    rgb_to_ycbcr_stream #(.DW(8), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mode     (i_mode),
        .i_s_valid  (i_s_valid),
        .o_s_ready  (o_s_ready),
        .i_s_data   (i_s_data),
        .i_s_sof    (i_s_sof),
        .i_s_eol    (i_s_eol),
        .o_m_valid  (o_m_valid),
        .i_m_ready  (i_m_ready),
        .o_m_data   (o_m_data),
        .o_m_sof    (o_m_sof),
        .o_m_eol    (o_m_eol),
        .o_clip_cnt (o_clip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] d;
        logic        sof;
        logic        eol;
        logic        clip;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by main
    logic        tb_mode_lat = 1'b0;
    logic [15:0] cnt_model = '0;
    logic        held = 1'b0;
    logic [25:0] held_val;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int clamp_i(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Reference conversion: returns {clip, Y, Cb, Cr}.
    function automatic logic [24:0] ref_px(input logic [23:0] px, input logic md);
        int r, g, b, y, cb, cr, ylo, yhi, clo, chi;
        logic clip;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
        if (md) begin
            y  = (66 * r + 129 * g + 25 * b + 16 * 256 + 128) >>> 8;
            cb = (-38 * r - 74 * g + 112 * b + 128 * 256 + 128) >>> 8;
            cr = (112 * r - 94 * g - 18 * b + 128 * 256 + 128) >>> 8;
            ylo = 16; yhi = 235; clo = 16; chi = 240;
        end else begin
            y  = (77 * r + 150 * g + 29 * b + 128) >>> 8;
            cb = (-43 * r - 85 * g + 128 * b + 128 * 256 + 128) >>> 8;
            cr = (128 * r - 107 * g - 21 * b + 128 * 256 + 128) >>> 8;
            ylo = 0; yhi = 255; clo = 0; chi = 255;
        end
        clip = (y != clamp_i(y, ylo, yhi)) || (cb != clamp_i(cb, clo, chi))
            || (cr != clamp_i(cr, clo, chi));
        return {clip, 8'(clamp_i(y, ylo, yhi)), 8'(clamp_i(cb, clo, chi)),
                8'(clamp_i(cr, clo, chi))};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) i_m_ready = 1'($urandom_range(0, 1));
            else if (rdy_mode == 0) i_m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (o_m_valid) begin
                if (held) check_eq("stall_stable", {o_m_data, o_m_sof, o_m_eol}, held_val);
                held     = !i_m_ready;
                held_val = {o_m_data, o_m_sof, o_m_eol};
                if (i_m_ready) begin
                    check_eq("out_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check_eq("m_data", o_m_data, e.d);
                        check_eq("m_sof", o_m_sof, e.sof);
                        check_eq("m_eol", o_m_eol, e.eol);
                        if (e.sof) cnt_model = 16'(e.clip);
                        else if (e.clip && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
                        check_eq("clip_cnt", o_clip_cnt, cnt_model);
                    end
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Holds s_valid until accepted; leaves it asserted so back-to-back sends run at 1 px/clk.
    task automatic send(input logic [23:0] px, input logic sof, input logic eol, input logic md,
                        input logic [23:0] exp_d, input logic exp_clip);
        logic ok;
        ok = 1'b0;
        i_s_valid = 1'b1;
        i_s_data  = px;
        i_s_sof   = sof;
        i_s_eol   = eol;
        i_mode    = md;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (o_s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("send_accept", ok, 1);
        if (ok) begin
            sb.push_back('{d: exp_d, sof: sof, eol: eol, clip: exp_clip});
            if (sof) tb_mode_lat = md;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_s_valid = 1'b0;
        i_s_sof   = 1'b0;
        i_s_eol   = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !o_m_valid) break;
        end
        check_eq("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand(input logic sof, input logic eol, input logic md);
        logic [23:0] px;
        logic [24:0] e;
        px = 24'($urandom);
        e  = ref_px(px, sof ? md : tb_mode_lat);
        send(px, sof, eol, md, e[23:0], e[24]);
    endtask

    // Free-running stream for ncyc cycles, counting accepts.
    task automatic stream_cycles(input int ncyc, output int nacc);
        logic [23:0] px;
        logic [24:0] e;
        logic        acc;
        nacc = 0;
        px = 24'($urandom);
        e  = ref_px(px, tb_mode_lat);
        i_s_valid = 1'b1; i_s_data = px; i_s_sof = 1'b0; i_s_eol = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            acc = o_s_ready;
            if (acc) begin
                sb.push_back('{d: e[23:0], sof: 1'b0, eol: 1'b0, clip: e[24]});
                nacc++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                px = 24'($urandom);
                e  = ref_px(px, tb_mode_lat);
                i_s_data = px;
            end
        end
        idle();
    endtask

    initial begin
        int lat, nacc;
        logic sof, md;
        rst_n = 1'b0; i_mode = 1'b0; i_m_ready = 1'b1; i_s_data = '0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_valid", o_m_valid, 0);
        check_eq("rst_m_data", o_m_data, 0);
        check_eq("rst_m_sof_eol", {o_m_sof, o_m_eol}, 0);
        check_eq("rst_clip_cnt", o_clip_cnt, 0);
        check_eq("rst_s_ready", o_s_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: black in full range, latency 3
        send(24'h000000, 1'b1, 1'b0, 1'b0, 24'h008080, 1'b0);
        idle();
        lat = 1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (o_m_valid) break;
            lat++;
        end
        check_eq("t1_latency", lat, 3);
        drain();
        check_eq("t1_clip_cnt", o_clip_cnt, 0);

        // T2: white and saturated red
        send(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 24'hFF8080, 1'b0);
        send(24'hFF0000, 1'b0, 1'b1, 1'b0, 24'h4D55FF, 1'b1);
        idle();
        drain();
        check_eq("t2_clip_cnt", o_clip_cnt, 1);

        // T3: limited range; mode toggle without SOF must be ignored
        send(24'h000000, 1'b1, 1'b0, 1'b1, 24'h108080, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b0, 1'b1, 24'hEB8080, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b1, 1'b0, 24'hEB8080, 1'b0);
        idle();
        drain();
        check_eq("t3_clip_cnt", o_clip_cnt, 0);

        // T4: 64 random pixels, random backpressure, random gaps
        rdy_mode = 1;
        for (int i = 0; i < 64; i++) begin
            sof = (i % 32 == 0);
            md  = 1'($urandom_range(0, 1));
            send_rand(sof, (i % 8 == 7), md);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        rdy_mode = 0; i_m_ready = 1'b1;
        drain();

        // T5: stall fills exactly three stages, then resumes at full rate
        rdy_mode = 2; i_m_ready = 1'b0;
        stream_cycles(10, nacc);
        check_eq("t5_stall_accepts", nacc, 3);
        rdy_mode = 0; i_m_ready = 1'b1;
        stream_cycles(8, nacc);
        check_eq("t5_resume_rate", nacc, 8);
        drain();

        // T6: reset mid-frame with clipped pixels in flight
        for (int i = 0; i < 5; i++) begin
            send(24'hFF0000, (i == 0), 1'b0, 1'b0, 24'h4D55FF, 1'b1);
        end
        check_eq("t6_pre_clip_nonzero", o_clip_cnt != 0, 1);
        idle();
        rst_n = 1'b0;
        sb.delete();
        held = 1'b0; tb_mode_lat = 1'b0; cnt_model = '0;
        #1;
        check_eq("t6_rst_m_valid", o_m_valid, 0);
        check_eq("t6_rst_clip_cnt", o_clip_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(24'h000000, 1'b0, 1'b0, 1'b1, 24'h008080, 1'b0);
        send(24'h000000, 1'b1, 1'b0, 1'b1, 24'h108080, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b1, 1'b1, 24'hEB8080, 1'b0);
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
